// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/192/256 encryptor: one round datapath reused every cycle under a four-state
// sequencer, with valid/ready handshakes on both the plaintext and the ciphertext side.
module aes_round_sequencer #(
    parameter int KEY_W  = 1920,
    parameter int NR_MAX = 14
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_data,
    input  logic [3:0]       i_nr,
    input  logic [KEY_W-1:0] i_expanded_key,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_data,
    output logic             o_busy,
    output logic [3:0]       o_round,
    output logic             o_err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (sh & {8{b[i]}});
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse as a^254 (a^240 * a^12 * a^2), then the affine map; zero maps to 0x63 naturally
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte k = 4*col + row sits at bits [127-8k -: 8]; row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    fsm_e         fsm_r, fsm_nxt;
    logic [127:0] state_r, state_nxt;
    logic [127:0] data_r, data_nxt;
    logic [3:0]   nr_r, nr_nxt;
    logic [3:0]   round_r, round_nxt;
    logic         valid_r, valid_nxt;
    logic         ready_r, ready_nxt;
    logic         busy_r, busy_nxt;
    logic         err_r, err_nxt;
    logic         nr_legal_s;
    logic [127:0] rk_s [0:NR_MAX];
    logic [127:0] sr_s, mc_s, round_out_s;

    for (genvar r = 0; r <= NR_MAX; r++) begin : g_rk
        assign rk_s[r] = i_expanded_key[KEY_W-1-128*r -: 128];
    end

    // In FINAL the round counter already equals nr, so one key mux serves both round kinds
    assign sr_s        = shift_rows(sub_bytes(state_r));
    assign mc_s        = mix_columns(sr_s);
    assign round_out_s = ((fsm_r == S_FINAL) ? sr_s : mc_s) ^ rk_s[round_r];
    assign nr_legal_s  = (i_nr == 4'd10) || (i_nr == 4'd12) || (i_nr == 4'd14);

    // Next-state, datapath update and next values of the registered outputs
    always_comb begin
        fsm_nxt   = fsm_r;
        state_nxt = state_r;
        data_nxt  = data_r;
        nr_nxt    = nr_r;
        round_nxt = round_r;
        err_nxt   = 1'b0;
        case (fsm_r)
            S_IDLE: begin
                if (i_valid && ready_r) begin
                    if (nr_legal_s) begin
                        state_nxt = i_data ^ rk_s[0];
                        nr_nxt    = i_nr;
                        round_nxt = 4'd1;
                        fsm_nxt   = S_ROUND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    fsm_nxt = S_IDLE;
                end
            end
            S_ROUND: begin
                state_nxt = round_out_s;
                round_nxt = round_r + 4'd1;
                if (round_r == nr_r - 4'd1) begin
                    fsm_nxt = S_FINAL;
                end else begin
                    fsm_nxt = S_ROUND;
                end
            end
            S_FINAL: begin
                state_nxt = round_out_s;
                data_nxt  = round_out_s;
                round_nxt = 4'd0;
                fsm_nxt   = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    fsm_nxt = S_IDLE;
                end else begin
                    fsm_nxt = S_DONE;
                end
            end
            default: begin
                fsm_nxt   = S_IDLE;
                round_nxt = 4'd0;
            end
        endcase
        ready_nxt = (fsm_nxt == S_IDLE);
        busy_nxt  = (fsm_nxt != S_IDLE);
        valid_nxt = (fsm_nxt == S_DONE);
    end

    // State and output registers; reset discards any block in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_r   <= S_IDLE;
            state_r <= 128'd0;
            data_r  <= 128'd0;
            nr_r    <= 4'd0;
            round_r <= 4'd0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            fsm_r   <= fsm_nxt;
            state_r <= state_nxt;
            data_r  <= data_nxt;
            nr_r    <= nr_nxt;
            round_r <= round_nxt;
            valid_r <= valid_nxt;
            ready_r <= ready_nxt;
            busy_r  <= busy_nxt;
            err_r   <= err_nxt;
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_data  = data_r;
    assign o_busy  = busy_r;
    assign o_round = round_r;
    assign o_err   = err_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors plus random blocks checked against a
// byte-matrix AES model with its own key expansion and generator-built S-box.
module tb_aes_round_sequencer;
    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [127:0]  i_data;
    logic [3:0]    i_nr;
    logic [1919:0] i_expanded_key;
    logic          o_valid;
    logic          i_ready;
    logic [127:0]  o_data;
    logic          o_busy;
    logic [3:0]    o_round;
    logic          o_err;

    int            checks_run;
    int            checks_passed;
    logic [7:0]    sbox_t [256];

    logic [1919:0] ek128, ek192, ek256, ek_v;
    logic [255:0]  key_v;
    logic [127:0]  pt_v, exp_v;
    int            nr_v, hold_v, n;
    logic [3:0]    bad_nr;

    localparam logic [127:0] T1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] T2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] T3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_sequencer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_nr           (i_nr),
        .i_expanded_key (i_expanded_key),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_round        (o_round),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_run++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // S-box from walking the generator 3 and its inverse around GF(2^8)*
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q ^ (q[7] ? 8'h09 : 8'h00);
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod, aa, bb;
        prod = 8'h00;
        aa   = a;
        bb   = b;
        while (bb != 8'h00) begin
            if (bb[0]) prod = prod ^ aa;
            aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return prod;
    endfunction

    function automatic logic [7:0] mix_coef(input int i);
        case (i)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ek;
        int            nwords;
        nwords = 4 * (nk + 7);
        rc = 8'h01;
        ek = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nwords; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = ref_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nwords; i++) ek[1919-32*i -: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1919:0] ek,
                                                 input int nr);
        logic [7:0]   st  [4][4];
        logic [7:0]   tmp [4][4];
        logic [127:0] rk, ct;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = pt[127-8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= nr; rnd++) begin
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) tmp[r][c] = sbox_t[st[r][(c+r)%4]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        if (rnd < nr) begin
                            st[r][c] = 8'h00;
                            for (int k = 0; k < 4; k++)
                                st[r][c] ^= ref_mul(mix_coef((k - r + 4) % 4), tmp[k][c]);
                        end else begin
                            st[r][c] = tmp[r][c];
                        end
                    end
            end
            rk = ek[1919-128*rnd -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] ^= rk[127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = st[r][c];
        return ct;
    endfunction

    // Called at a negedge; returns just after the accepting posedge
    task automatic start_block(input logic [127:0] pt, input logic [1919:0] ek, input int nr,
                               input int hold);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("ready_before_send", 128'(o_ready), 128'd1);
        i_valid        = 1'b1;
        i_data         = pt;
        i_nr           = 4'(nr);
        i_expanded_key = ek;
        i_ready        = (hold == 0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = {$urandom, $urandom, $urandom, $urandom};
        i_nr    = 4'($urandom_range(0, 15));
    endtask

    task automatic finish_block(input string tag, input int nr, input logic [127:0] exp,
                                input int hold);
        int lat;
        bit rounds_ok, stable;
        @(negedge clk);
        rounds_ok = (o_round == 4'd1) && o_busy && !o_ready && !o_valid;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!o_valid) rounds_ok = rounds_ok && (o_round == 4'(lat + 1)) && o_busy && !o_ready;
        end
        check_eq({tag, "_latency"}, 128'(lat), 128'(nr));
        check_eq({tag, "_round_seq"}, 128'(rounds_ok), 128'd1);
        check_eq({tag, "_ciphertext"}, o_data, exp);
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            if (k == hold / 2) begin
                i_valid = 1'b1;
                i_data  = {$urandom, $urandom, $urandom, $urandom};
                i_nr    = 4'd10;
            end
            @(negedge clk);
            stable = stable && o_valid && (o_data === exp) && !o_ready && o_busy && (o_round == 4'd0);
        end
        if (hold > 0) check_eq({tag, "_hold_stable"}, 128'(stable), 128'd1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_post_handshake"}, 128'({o_valid, o_ready, o_busy}), 128'(3'b010));
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [1919:0] ek,
                             input int nr, input logic [127:0] exp, input int hold);
        start_block(pt, ek, nr, hold);
        finish_block(tag, nr, exp, hold);
    endtask

    task automatic send_illegal(input logic [3:0] nr);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        i_valid = 1'b1;
        i_nr    = nr;
        i_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check_eq("err_pulse", 128'({o_err, o_busy, o_valid}), 128'(3'b100));
        @(negedge clk);
        check_eq("err_clear", 128'({o_err, o_busy, o_valid, o_ready}), 128'(4'b0001));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_run     = 0;
        checks_passed  = 0;
        build_sbox();
        ek128 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'd0}, 4);
        ek192 = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0}, 6);
        ek256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        rst_n          = 1'b1;
        i_valid        = 1'b0;
        i_ready        = 1'b1;
        i_data         = 128'd0;
        i_nr           = 4'd0;
        i_expanded_key = '0;
        #3 rst_n = 1'b0;
        #1;
        check_eq("reset_ctl", 128'({o_valid, o_busy, o_err, o_round}), 128'd0);
        check_eq("reset_data", o_data, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 128'({o_ready, o_busy, o_valid}), 128'(3'b100));

        run_block("t1_aes128", T1_PT, ek128, 10, T1_CT, 0);
        run_block("t2_aes192", T1_PT, ek192, 12, T2_CT, 0);
        run_block("t2_aes256", T1_PT, ek256, 14, T3_CT, 0);
        run_block("t3_backpressure", T1_PT, ek128, 10, T1_CT, 20);

        send_illegal(4'd11);
        run_block("t4_after_err", T1_PT, ek128, 10, T1_CT, 0);

        start_block(T1_PT, ek128, 10, 0);
        n = 0;
        while (o_round != 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_reach_round5", 128'(o_round), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_ctl", 128'({o_valid, o_busy, o_err, o_round}), 128'd0);
        check_eq("t5_async_data", o_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_after_release", 128'({o_valid, o_ready, o_busy}), 128'(3'b010));
        run_block("t5_rerun", T1_PT, ek128, 10, T1_CT, 0);

        run_block("t6_first", T1_PT, ek128, 10, T1_CT, 0);
        run_block("t6_second", T1_PT, ek192, 12, T2_CT, 0);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                do bad_nr = 4'($urandom_range(0, 15));
                while (bad_nr == 4'd10 || bad_nr == 4'd12 || bad_nr == 4'd14);
                send_illegal(bad_nr);
            end
            nr_v   = 10 + 2 * int'($urandom_range(0, 2));
            key_v  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt_v   = {$urandom, $urandom, $urandom, $urandom};
            ek_v   = expand_key(key_v, nr_v - 6);
            exp_v  = ref_encrypt(pt_v, ek_v, nr_v);
            hold_v = int'($urandom_range(0, 3));
            run_block("rand", pt_v, ek_v, nr_v, exp_v, hold_v);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_run);
        $finish;
    end

endmodule
